// File: rtl/gpu_shader_core_seq_if.sv
// rtl/gpu_shader_core_seq_if.sv - instruction/data RAM bus between the shader core and its memories
interface gpu_shader_core_seq_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic [31:0]           inst_rdata;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [31:0]           data_wdata;
  logic                  data_write;
  logic [31:0]           data_rdata;

  modport master (
    output inst_addr,
    input  inst_rdata,
    output data_addr,
    output data_wdata,
    output data_write,
    input  data_rdata
  );

  modport slave (
    input  inst_addr,
    output inst_rdata,
    input  data_addr,
    input  data_wdata,
    input  data_write,
    output data_rdata
  );
endinterface

// File: rtl/gpu_shader_core_seq.sv
// rtl/gpu_shader_core_seq.sv - multi-cycle RV32I sequencer for one shader core
// Owns PC, register file and the FETCH/DECODE/EXEC/MEM/WB state machine; RAMs are external.
module gpu_shader_core_seq #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          INST_LAT   = 1,
  parameter int          DATA_LAT   = 1,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  run,
  output logic                  halted,
  output logic                  error,
  output logic [31:0]           pc,
  output logic [31:0]           retired,
  gpu_shader_core_seq_if.master mem,
  input  logic [4:0]            reg_ext_address,
  output logic [31:0]           reg_ext_data
);

  localparam int MAX_LAT = (INST_LAT > DATA_LAT) ? INST_LAT : DATA_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   retired_q, retired_d;
  logic          error_q, error_d;
  logic [31:0]   ir_q, ir_d;
  logic [31:0]   rs1_q, rs1_d;
  logic [31:0]   rs2_q, rs2_d;
  logic [31:0]   res_q, res_d;
  logic [31:0]   npc_q, npc_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;

  logic [31:0] rf_q [32];

  // Instruction fields are decoded from the latched IR in every state after FETCH.
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1_idx, rs2_idx;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign funct3  = ir_q[14:12];
  assign rs1_idx = ir_q[19:15];
  assign rs2_idx = ir_q[24:20];
  assign funct7  = ir_q[31:25];
  assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u   = {ir_q[31:12], 12'b0};
  assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] alu;
  logic        br_cond;

  always_comb begin
    op_b  = (opcode == OPC_OP) ? rs2_q : imm_i;
    shamt = op_b[4:0];
    alu   = '0;
    unique case (funct3)
      3'b000: alu = (opcode == OPC_OP && funct7[5]) ? rs1_q - op_b : rs1_q + op_b;
      3'b001: alu = rs1_q << shamt;
      3'b010: alu = {31'b0, $signed(rs1_q) < $signed(op_b)};
      3'b011: alu = {31'b0, rs1_q < op_b};
      3'b100: alu = rs1_q ^ op_b;
      3'b101: alu = funct7[5] ? 32'($signed(rs1_q) >>> shamt) : rs1_q >> shamt;
      3'b110: alu = rs1_q | op_b;
      3'b111: alu = rs1_q & op_b;
      default: alu = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    unique case (funct3)
      3'b000: br_cond = (rs1_q == rs2_q);
      3'b001: br_cond = (rs1_q != rs2_q);
      3'b100: br_cond = ($signed(rs1_q) < $signed(rs2_q));
      3'b101: br_cond = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110: br_cond = (rs1_q < rs2_q);
      3'b111: br_cond = (rs1_q >= rs2_q);
      default: br_cond = 1'b0;
    endcase
  end

  logic                  ex_legal, ex_mem, ex_take, ex_fault, ex_ebreak;
  logic [31:0]           ex_res, ex_tgt, ex_npc, mem_imm;
  logic [ADDR_WIDTH-1:0] ex_maddr;

  always_comb begin
    ex_legal = 1'b0;
    ex_mem   = 1'b0;
    ex_take  = 1'b0;
    ex_res   = alu;
    ex_tgt   = pc_q + imm_b;
    mem_imm  = (opcode == OPC_STORE) ? imm_s : imm_i;
    ex_maddr = ADDR_WIDTH'(rs1_q + mem_imm);
    unique case (opcode)
      OPC_LUI: begin
        ex_legal = 1'b1;
        ex_res   = imm_u;
      end
      OPC_AUIPC: begin
        ex_legal = 1'b1;
        ex_res   = pc_q + imm_u;
      end
      OPC_JAL: begin
        ex_legal = 1'b1;
        ex_res   = pc_q + 32'd4;
        ex_take  = 1'b1;
        ex_tgt   = pc_q + imm_j;
      end
      OPC_JALR: begin
        ex_legal = (funct3 == 3'b000);
        ex_res   = pc_q + 32'd4;
        ex_take  = 1'b1;
        ex_tgt   = (rs1_q + imm_i) & 32'hFFFF_FFFE;
      end
      OPC_BRANCH: begin
        ex_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
        ex_take  = br_cond;
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b001) begin
          ex_legal = (funct7 == 7'b0000000);
        end else if (funct3 == 3'b101) begin
          ex_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        end else begin
          ex_legal = 1'b1;
        end
      end
      OPC_OP: begin
        ex_legal = (funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_LOAD, OPC_STORE: begin
        ex_legal = (funct3 == 3'b010);
        ex_mem   = 1'b1;
      end
      default: ex_legal = 1'b0;
    endcase
    ex_ebreak = (ir_q == EBREAK);
    // A control transfer to a halfword-aligned target faults before anything is committed.
    ex_fault  = !ex_ebreak && (!ex_legal || (ex_mem && ex_maddr[1:0] != 2'b00) ||
                               (ex_take && ex_tgt[1]));
    ex_npc    = ex_take ? ex_tgt : pc_q + 32'd4;
  end

  logic rd_writes;
  assign rd_writes = (opcode != OPC_BRANCH) && (opcode != OPC_STORE) && (rd != 5'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    error_d   = error_q;
    ir_d      = ir_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    res_d     = res_q;
    npc_d     = npc_q;
    maddr_d   = maddr_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (run) begin
          state_d   = S_FETCH;
          cnt_d     = '0;
          pc_d      = RESET_PC;
          retired_d = '0;
          error_d   = 1'b0;
        end
      end
      S_FETCH: begin
        if (cnt_q == CW'(INST_LAT - 1)) begin
          ir_d    = mem.inst_rdata;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        rs1_d   = (rs1_idx == 5'd0) ? 32'h0 : rf_q[rs1_idx];
        rs2_d   = (rs2_idx == 5'd0) ? 32'h0 : rf_q[rs2_idx];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = ex_res;
        npc_d   = ex_npc;
        maddr_d = ex_maddr;
        cnt_d   = '0;
        if (ex_ebreak || ex_fault) begin
          state_d = S_HALT;
          error_d = ex_fault;
        end else if (ex_mem) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (cnt_q == CW'(DATA_LAT - 1)) begin
          if (opcode == OPC_LOAD) begin
            res_d = mem.data_rdata;
          end
          cnt_d   = '0;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB: begin
        pc_d      = npc_q;
        retired_d = retired_q + 32'd1;
        cnt_d     = '0;
        state_d   = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      error_q   <= error_d;
    end
    ir_q    <= ir_d;
    rs1_q   <= rs1_d;
    rs2_q   <= rs2_d;
    res_q   <= res_d;
    npc_q   <= npc_d;
    maddr_q <= maddr_d;
  end

  // x0 is never written, so its storage stays undefined; every read path masks it to zero.
  always_ff @(posedge clock) begin
    if (reset_n && state_q == S_WB && rd_writes) begin
      rf_q[rd] <= res_q;
    end
  end

  assign halted         = (state_q == S_IDLE) || (state_q == S_HALT);
  assign error          = error_q;
  assign pc             = pc_q;
  assign retired        = retired_q;
  assign mem.inst_addr  = pc_q[ADDR_WIDTH-1:0];
  assign mem.data_addr  = maddr_q;
  assign mem.data_wdata = rs2_q;
  assign mem.data_write = (state_q == S_MEM) && (cnt_q == '0) && (opcode == OPC_STORE);
  assign reg_ext_data   = (reg_ext_address == 5'd0) ? 32'h0 : rf_q[reg_ext_address];

endmodule

// File: tb/tb_gpu_shader_core_seq.sv
// tb/tb_gpu_shader_core_seq.sv - directed scoreboard bench for gpu_shader_core_seq
module tb_gpu_shader_core_seq;
  localparam int AW = 16;
  localparam int K_REG = 0, K_PC = 1, K_RET = 2, K_ERR = 3, K_HALT = 4, K_CYC = 5;
  localparam int K_WRN = 6, K_WRA = 7, K_DMEM = 8, K_PCSEQ = 9, K_PCN = 10;
  localparam int K_SERR = 11, K_SRET = 12, K_SPC = 13;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        halted, error;
  logic [31:0] pc, retired, reg_ext_data;
  logic [4:0]  reg_ext_address = 5'd0;

  gpu_shader_core_seq_if #(.ADDR_WIDTH(AW)) bus ();

  gpu_shader_core_seq #(.ADDR_WIDTH(AW), .INST_LAT(1), .DATA_LAT(2), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .halted(halted), .error(error),
    .pc(pc), .retired(retired), .mem(bus),
    .reg_ext_address(reg_ext_address), .reg_ext_data(reg_ext_data)
  );

  always #5 clock = ~clock;

  logic [31:0]   imem [16384];
  logic [31:0]   dmem [16384];
  logic [AW-1:0] daddr_d1;
  logic [AW-1:0] wr_addr;
  int            wr_cnt;

  // Instruction RAM answers in the same cycle; data RAM has one register stage (latency 2).
  assign bus.inst_rdata = (bus.inst_addr[1:0] == 2'b00) ? imem[bus.inst_addr[AW-1:2]] : 32'h0;
  assign bus.data_rdata = (daddr_d1[1:0] == 2'b00) ? dmem[daddr_d1[AW-1:2]] : 32'h0;

  always @(posedge clock) begin
    daddr_d1 <= bus.data_addr;
    if (bus.data_write) begin
      dmem[bus.data_addr[AW-1:2]] <= bus.data_wdata;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.data_addr;
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc_last, wr_base;
  logic [31:0] start_err, start_ret, start_pc;
  logic [31:0] pc_log [$];
  logic [31:0] prog [$];
  string       tag_q [$];
  int          kind_q [$];
  int          idx_q [$];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] e_i(input logic [6:0] opc, input logic [2:0] f3, input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], f3, rd[4:0], opc};
  endfunction
  function automatic logic [31:0] e_r(input logic [6:0] f7, input int rs2, input int rs1, input logic [2:0] f3, input int rd);
    return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] e_s(input int rs2, input int rs1, input int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] e_b(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] e_j(input int rd, input int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
  endfunction
  function automatic logic [31:0] e_u(input logic [6:0] opc, input int rd, input int imm20);
    return {imm20[19:0], rd[4:0], opc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int kind, input int idx, input logic [31:0] v);
    tag_q.push_back(tag);
    kind_q.push_back(kind);
    idx_q.push_back(idx);
    exp_q.push_back(v);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 128; i++) imem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
    prog.delete();
    wr_base = wr_cnt;
  endtask

  task automatic run_prog(input int pulse_at);
    @(negedge clock);
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    start_err = {31'b0, error};
    start_ret = retired;
    start_pc  = pc;
    pc_log.delete();
    pc_log.push_back(pc);
    cyc_last = 0;
    while (!halted && cyc_last < 2000) begin
      run = (cyc_last == pulse_at);
      @(negedge clock);
      cyc_last++;
      if (pc !== pc_log[$]) pc_log.push_back(pc);
    end
    run = 1'b0;
    chk("halt_wait", {31'b0, halted}, 32'h1);
  endtask

  task automatic drain();
    string       t;
    int          k, ix;
    logic [31:0] e, o;
    while (kind_q.size() > 0) begin
      t  = tag_q.pop_front();
      k  = kind_q.pop_front();
      ix = idx_q.pop_front();
      e  = exp_q.pop_front();
      o  = 'x;
      case (k)
        K_REG:   begin reg_ext_address = ix[4:0]; #1; o = reg_ext_data; end
        K_PC:    o = pc;
        K_RET:   o = retired;
        K_ERR:   o = {31'b0, error};
        K_HALT:  o = {31'b0, halted};
        K_CYC:   o = 32'(cyc_last);
        K_WRN:   o = 32'(wr_cnt - wr_base);
        K_WRA:   o = {16'b0, wr_addr};
        K_DMEM:  o = dmem[ix];
        K_PCSEQ: if (ix < pc_log.size()) o = pc_log[ix];
        K_PCN:   o = 32'(pc_log.size());
        K_SERR:  o = start_err;
        K_SRET:  o = start_ret;
        K_SPC:   o = start_pc;
        default: o = 'x;
      endcase
      chk(t, o, e);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_halted", {31'b0, halted}, 32'h1);
    chk("rst_pc", pc, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_error", {31'b0, error}, 32'h0);
    chk("rst_write", {31'b0, bus.data_write}, 32'h0);
    reset_n = 1'b1;

    // ADDI chain then EBREAK
    prog.push_back(e_i(7'h13, 3'b000, 1, 0, 5));
    prog.push_back(e_i(7'h13, 3'b000, 1, 1, -7));
    prog.push_back(EBRK);
    load_prog();
    expect_val("t1_x1", K_REG, 1, 32'hFFFF_FFFE);
    expect_val("t1_ret", K_RET, 0, 32'd2);
    expect_val("t1_pc", K_PC, 0, 32'd8);
    expect_val("t1_err", K_ERR, 0, 32'd0);
    expect_val("t1_cyc", K_CYC, 0, 32'd11);
    run_prog(-1);
    drain();

    // SW then LW through the latency-2 data RAM
    prog.push_back(e_u(7'h37, 1, 1));
    prog.push_back(e_i(7'h13, 3'b000, 1, 1, 32'h234));
    prog.push_back(e_s(1, 0, 32'h40));
    prog.push_back(e_i(7'h03, 3'b010, 2, 0, 32'h40));
    prog.push_back(EBRK);
    load_prog();
    expect_val("t2_x2", K_REG, 2, 32'h1234);
    expect_val("t2_wrn", K_WRN, 0, 32'd1);
    expect_val("t2_wra", K_WRA, 0, 32'h40);
    expect_val("t2_dmem", K_DMEM, 16, 32'h1234);
    expect_val("t2_ret", K_RET, 0, 32'd4);
    expect_val("t2_cyc", K_CYC, 0, 32'd23);
    run_prog(-1);
    drain();

    // seed x1=-1, x5=0, x12=0
    prog.push_back(e_i(7'h13, 3'b000, 1, 0, -1));
    prog.push_back(e_i(7'h13, 3'b000, 5, 0, 0));
    prog.push_back(e_i(7'h13, 3'b000, 12, 0, 0));
    prog.push_back(EBRK);
    load_prog();
    expect_val("t3_seed_x1", K_REG, 1, 32'hFFFF_FFFF);
    run_prog(-1);
    drain();

    // BLT taken, BLTU not taken, JAL to a halfword target faults
    prog.push_back(e_b(3'b100, 1, 0, 8));
    prog.push_back(e_i(7'h13, 3'b000, 5, 0, 7));
    prog.push_back(e_b(3'b110, 1, 0, 8));
    prog.push_back(e_j(0, 6));
    load_prog();
    expect_val("t3_pcseq0", K_PCSEQ, 0, 32'd0);
    expect_val("t3_pcseq1", K_PCSEQ, 1, 32'd8);
    expect_val("t3_pcseq2", K_PCSEQ, 2, 32'd12);
    expect_val("t3_pcn", K_PCN, 0, 32'd3);
    expect_val("t3_x5", K_REG, 5, 32'd0);
    expect_val("t3_err", K_ERR, 0, 32'd1);
    expect_val("t3_ret", K_RET, 0, 32'd2);
    expect_val("t3_cyc", K_CYC, 0, 32'd11);
    run_prog(-1);
    drain();

    // write to x0 discarded; LB is illegal
    prog.push_back(e_i(7'h13, 3'b000, 0, 0, 9));
    prog.push_back(e_i(7'h03, 3'b000, 3, 0, 0));
    load_prog();
    expect_val("t4_x0", K_REG, 0, 32'd0);
    expect_val("t4_err", K_ERR, 0, 32'd1);
    expect_val("t4_ret", K_RET, 0, 32'd1);
    expect_val("t4_pc", K_PC, 0, 32'd4);
    run_prog(-1);
    drain();

    // restart from an error halt with a stray run pulse mid-program
    prog.push_back(e_i(7'h13, 3'b000, 6, 0, 1));
    prog.push_back(e_i(7'h13, 3'b000, 6, 6, 1));
    prog.push_back(e_i(7'h13, 3'b000, 6, 6, 1));
    prog.push_back(EBRK);
    load_prog();
    expect_val("t6_start_err", K_SERR, 0, 32'd0);
    expect_val("t6_start_ret", K_SRET, 0, 32'd0);
    expect_val("t6_start_pc", K_SPC, 0, 32'd0);
    expect_val("t6_x6", K_REG, 6, 32'd3);
    expect_val("t6_ret", K_RET, 0, 32'd3);
    expect_val("t6_pc", K_PC, 0, 32'd12);
    expect_val("t6_err", K_ERR, 0, 32'd0);
    expect_val("t6_cyc", K_CYC, 0, 32'd15);
    run_prog(5);
    drain();

    // reset asserted in the second MEM cycle of a SW
    prog.push_back(e_i(7'h13, 3'b000, 4, 0, 3));
    prog.push_back(e_s(4, 0, 32'h44));
    prog.push_back(EBRK);
    load_prog();
    @(negedge clock);
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    for (int n = 0; n < 50 && !bus.data_write; n++) @(negedge clock);
    chk("t5_sw_strobe", {31'b0, bus.data_write}, 32'h1);
    chk("t5_pre_pc", pc, 32'd4);
    chk("t5_pre_ret", retired, 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("t5_rst_halted", {31'b0, halted}, 32'h1);
    chk("t5_rst_write", {31'b0, bus.data_write}, 32'h0);
    chk("t5_rst_pc", pc, 32'h0);
    chk("t5_rst_ret", retired, 32'h0);
    reset_n = 1'b1;
    wr_base = wr_cnt;
    expect_val("t5_x4", K_REG, 4, 32'd3);
    expect_val("t5_dmem", K_DMEM, 17, 32'd3);
    expect_val("t5_wrn", K_WRN, 0, 32'd1);
    expect_val("t5_ret", K_RET, 0, 32'd2);
    expect_val("t5_pc", K_PC, 0, 32'd8);
    expect_val("t5_cyc", K_CYC, 0, 32'd13);
    run_prog(-1);
    drain();

    // ALU, AUIPC, JALR and BNE mix
    prog.push_back(e_i(7'h13, 3'b000, 1, 0, -16));
    prog.push_back(e_i(7'h13, 3'b000, 2, 0, 3));
    prog.push_back(e_r(7'h20, 1, 2, 3'b000, 3));
    prog.push_back(e_r(7'h00, 2, 1, 3'b010, 4));
    prog.push_back(e_r(7'h00, 2, 1, 3'b011, 5));
    prog.push_back(e_r(7'h20, 2, 1, 3'b101, 6));
    prog.push_back(e_r(7'h00, 2, 1, 3'b101, 7));
    prog.push_back(e_r(7'h00, 2, 2, 3'b001, 8));
    prog.push_back(e_i(7'h13, 3'b100, 9, 1, 255));
    prog.push_back(e_u(7'h17, 10, 1));
    prog.push_back(e_i(7'h67, 3'b000, 11, 0, 53));
    prog.push_back(e_i(7'h13, 3'b000, 12, 0, 1));
    prog.push_back(e_i(7'h13, 3'b000, 12, 0, 2));
    prog.push_back(e_b(3'b001, 2, 0, 8));
    prog.push_back(e_i(7'h13, 3'b000, 12, 0, 3));
    prog.push_back(e_r(7'h00, 2, 1, 3'b110, 13));
    prog.push_back(e_i(7'h13, 3'b111, 14, 1, 60));
    prog.push_back(e_i(7'h13, 3'b101, 15, 1, 32'h402));
    prog.push_back(EBRK);
    load_prog();
    expect_val("t7_sub", K_REG, 3, 32'h13);
    expect_val("t7_slt", K_REG, 4, 32'h1);
    expect_val("t7_sltu", K_REG, 5, 32'h0);
    expect_val("t7_sra", K_REG, 6, 32'hFFFF_FFFE);
    expect_val("t7_srl", K_REG, 7, 32'h1FFF_FFFE);
    expect_val("t7_sll", K_REG, 8, 32'h18);
    expect_val("t7_xori", K_REG, 9, 32'hFFFF_FF0F);
    expect_val("t7_auipc", K_REG, 10, 32'h1024);
    expect_val("t7_jalr_link", K_REG, 11, 32'h2C);
    expect_val("t7_skipped", K_REG, 12, 32'h0);
    expect_val("t7_or", K_REG, 13, 32'hFFFF_FFF3);
    expect_val("t7_andi", K_REG, 14, 32'h30);
    expect_val("t7_srai", K_REG, 15, 32'hFFFF_FFFC);
    expect_val("t7_ret", K_RET, 0, 32'd15);
    expect_val("t7_pc", K_PC, 0, 32'd72);
    expect_val("t7_cyc", K_CYC, 0, 32'd63);
    run_prog(-1);
    drain();

    // misaligned SW halts in EXEC without touching memory
    prog.push_back(e_s(1, 0, 32'h42));
    load_prog();
    expect_val("t8_err", K_ERR, 0, 32'd1);
    expect_val("t8_pc", K_PC, 0, 32'd0);
    expect_val("t8_ret", K_RET, 0, 32'd0);
    expect_val("t8_wrn", K_WRN, 0, 32'd0);
    expect_val("t8_cyc", K_CYC, 0, 32'd3);
    run_prog(-1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
